// File: rtl/step_loader.sv
// step_loader: decodes a 32-bit command word stream into per-channel step queue
// writes, a broadcast clock reload, and per-channel reset strobes.
module step_loader #(
  parameter int NUM_CHANNELS       = 4,
  parameter int MOVE_TYPE_BITS     = 3,
  parameter int STEP_INTERVAL_BITS = 32,
  parameter int STEP_COUNT_BITS    = 32,
  parameter int STEP_ADD_BITS      = 32,
  localparam int DW = MOVE_TYPE_BITS + STEP_INTERVAL_BITS + STEP_COUNT_BITS + STEP_ADD_BITS + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DW-1:0]           q_wr_data,
  output logic [NUM_CHANNELS-1:0] q_wr_en,
  input  logic [NUM_CHANNELS-1:0] q_full,
  output logic                    do_reset_clock,
  output logic [31:0]             reset_clock,
  output logic [NUM_CHANNELS-1:0] ch_reset,
  output logic                    busy,
  output logic [1:0]              err,
  input  logic                    err_clear
);

  localparam logic [3:0] OP_MOVE      = 4'd1;
  localparam logic [3:0] OP_SET_CLOCK = 4'd2;
  localparam logic [3:0] OP_CH_RESET  = 4'd3;

  typedef enum logic [2:0] {HDR, ARG0, ARG1, ARG2, WRITE} state_t;

  state_t state, state_nxt;

  logic [3:0]                    op_r;
  logic                          ch_bad_r;
  logic [NUM_CHANNELS-1:0]       ch_oh_r;
  logic                          dir_r;
  logic [MOVE_TYPE_BITS-1:0]     mt_r;
  logic [STEP_INTERVAL_BITS-1:0] interval_r;
  logic [STEP_COUNT_BITS-1:0]    count_r;

  logic                    acc;
  logic [3:0]              hdr_op;
  logic                    hdr_ch_bad;
  logic [NUM_CHANNELS-1:0] hdr_oh;
  logic                    full_sel;
  logic [1:0]              err_set;

  assign acc    = in_valid & in_ready;
  assign hdr_op = in_data[31:28];
  // A channel field beyond the attached queues selects nothing (one-hot is zero).
  assign hdr_ch_bad = ({1'b0, in_data[27:24]} >= 5'(NUM_CHANNELS));
  assign full_sel   = |(q_full & ch_oh_r);

  // Header channel field decoded to a one-hot over the attached channels.
  always_comb begin
    hdr_oh = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      hdr_oh[i] = (in_data[27:24] == 4'(i));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HDR;
    else       state <= state_nxt;
  end

  // Next-state, handshake and combinational strobe outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = (state != WRITE) && !reset;
    busy      = (state != HDR);
    q_wr_en   = '0;
    err_set   = 2'b00;
    case (state)
      HDR: if (acc) begin
        case (hdr_op)
          OP_MOVE, OP_SET_CLOCK: state_nxt = ARG0;
          OP_CH_RESET:           err_set[0] = hdr_ch_bad;
          default:               err_set[1] = 1'b1;
        endcase
      end
      ARG0: if (acc) state_nxt = (op_r == OP_SET_CLOCK) ? HDR : ARG1;
      ARG1: if (acc) state_nxt = ARG2;
      ARG2: if (acc) begin
        // A bad-channel MOVE still swallows its arguments, then is dropped.
        state_nxt  = ch_bad_r ? HDR : WRITE;
        err_set[0] = ch_bad_r;
      end
      WRITE: if (!full_sel) begin
        q_wr_en   = ch_oh_r;
        state_nxt = HDR;
      end
      default: state_nxt = HDR;
    endcase
  end

  // Command fields, registered queue entry, one-cycle strobes and sticky errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r           <= '0;
      ch_bad_r       <= 1'b0;
      ch_oh_r        <= '0;
      dir_r          <= 1'b0;
      mt_r           <= '0;
      interval_r     <= '0;
      count_r        <= '0;
      q_wr_data      <= '0;
      do_reset_clock <= 1'b0;
      reset_clock    <= '0;
      ch_reset       <= '0;
      err            <= 2'b00;
    end else begin
      do_reset_clock <= 1'b0;
      ch_reset       <= '0;
      // Set has priority over clear.
      err <= (err_clear ? 2'b00 : err) | err_set;
      if (acc) begin
        case (state)
          HDR: begin
            op_r     <= hdr_op;
            ch_bad_r <= hdr_ch_bad;
            ch_oh_r  <= hdr_oh;
            dir_r    <= in_data[23];
            mt_r     <= in_data[MOVE_TYPE_BITS-1:0];
            if (hdr_op == OP_CH_RESET) ch_reset <= hdr_oh;
          end
          ARG0: begin
            if (op_r == OP_SET_CLOCK) begin
              do_reset_clock <= 1'b1;
              reset_clock    <= in_data;
            end else begin
              interval_r <= in_data[STEP_INTERVAL_BITS-1:0];
            end
          end
          ARG1: count_r <= in_data[STEP_COUNT_BITS-1:0];
          ARG2: if (!ch_bad_r)
            q_wr_data <= {dir_r, interval_r, count_r, in_data[STEP_ADD_BITS-1:0], mt_r};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_loader.sv
// Scoreboard bench for step_loader: the stimulus thread pushes expected strobes,
// a negedge monitor pops and compares whenever any strobe is seen.
module tb_step_loader;

  localparam int NC = 4;
  localparam int DW = 3 + 32 + 32 + 32 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] q_wr_data;
  logic [NC-1:0] q_wr_en;
  logic [NC-1:0] q_full;
  logic          do_reset_clock;
  logic [31:0]   reset_clock;
  logic [NC-1:0] ch_reset;
  logic          busy;
  logic [1:0]    err;
  logic          err_clear;

  step_loader #(.NUM_CHANNELS(NC)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .q_wr_data(q_wr_data), .q_wr_en(q_wr_en),
    .q_full(q_full), .do_reset_clock(do_reset_clock), .reset_clock(reset_clock),
    .ch_reset(ch_reset), .busy(busy), .err(err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*NC:0] strobes;  // {q_wr_en, ch_reset, do_reset_clock}
    logic [DW-1:0] data;     // q_wr_data for writes, reset_clock in low bits for reloads
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe cycle must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (!reset && (|q_wr_en || |ch_reset || do_reset_clock)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_strobe: got wr=%b chr=%b clk=%b expected none", q_wr_en, ch_reset, do_reset_clock);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobes", 128'({q_wr_en, ch_reset, do_reset_clock}), 128'(e.strobes));
        chk("strobe_cycle", 128'(cyc), 128'(e.due));
        if (|q_wr_en)      chk("q_wr_data", 128'(q_wr_data), 128'(e.data));
        if (do_reset_clock) chk("reset_clock", 128'(reset_clock), 128'(e.data));
      end
    end
  end

  // Drive one word once in_ready is high; returns the cycle of the accepting edge.
  task automatic send(input logic [31:0] w, output int acc_cyc);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic push(input logic [2*NC:0] s, input logic [DW-1:0] d, input int due);
    exp_t e;
    e.strobes = s; e.data = d; e.due = due;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int a;
  logic [DW-1:0] mv;

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; q_full = '0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    // Outputs while reset is held.
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_q_wr_data", 128'(q_wr_data), 128'(0));
    chk("rst_reset_clock", 128'(reset_clock), 128'(0));
    chk("rst_strobes", 128'({q_wr_en, ch_reset, do_reset_clock}), 128'(0));
    @(posedge clk); #1 reset = 1'b0;
    idle(1);
    chk("idle_ready", 128'(in_ready), 128'(1));

    // MOVE ch2, dir=1, type=0: write one cycle after the add word.
    mv = {1'b1, 32'h100, 32'd5, 32'hFFFF_FFFE, 3'b000};
    send(32'h1280_0000, a);
    chk("busy_arg", 128'(busy), 128'(1));
    send(32'h0000_0100, a);
    send(32'h0000_0005, a);
    send(32'hFFFF_FFFE, a);
    push({4'b0100, 4'b0000, 1'b0}, mv, a);
    idle(2);

    // Same MOVE with ch2 full for 10 cycles.
    q_full = 4'b0100;
    send(32'h1280_0000, a);
    send(32'h0000_0100, a);
    send(32'h0000_0005, a);
    send(32'hFFFF_FFFE, a);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_ready", 128'(in_ready), 128'(0));
      chk("stall_wr_en", 128'(q_wr_en), 128'(0));
    end
    chk("stall_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    push({4'b0100, 4'b0000, 1'b0}, mv, cyc);
    q_full = 4'b0000;
    idle(2);

    // MOVE ch0, dir=0, type=5: another field pattern, other channels full.
    q_full = 4'b1110;
    send(32'h1000_0005, a);
    send(32'hDEAD_BEEF, a);
    send(32'h0000_0001, a);
    send(32'h8000_0000, a);
    push({4'b0001, 4'b0000, 1'b0}, {1'b0, 32'hDEAD_BEEF, 32'd1, 32'h8000_0000, 3'd5}, a);
    idle(2);
    q_full = 4'b0000;

    // SET_CLOCK.
    send(32'h2F00_0000, a);
    send(32'h1234_5678, a);
    push({4'b0000, 4'b0000, 1'b1}, DW'(32'h1234_5678), a);
    idle(2);

    // MOVE to ch7: arguments swallowed, err[0] set, then cleared.
    send(32'h1700_0000, a);
    send(32'h0000_0001, a);
    send(32'h0000_0002, a);
    chk("badch_err_pending", 128'(err), 128'(0));
    send(32'h0000_0003, a);
    chk("badch_err", 128'(err), 128'(2'b01));
    chk("badch_hdr", 128'(busy), 128'(0));
    err_clear = 1'b1; @(posedge clk); #1 err_clear = 1'b0;
    chk("err_clear", 128'(err), 128'(0));

    // Unknown opcode, then CH_RESET ch1 decoded as a header.
    send(32'hF000_0000, a);
    chk("badop_err", 128'(err), 128'(2'b10));
    chk("badop_hdr", 128'(busy), 128'(0));
    send(32'h3100_0000, a);
    push({4'b0000, 4'b0010, 1'b0}, '0, a);
    idle(1);

    // Error set wins over a simultaneous clear.
    err_clear = 1'b1;
    send(32'h3900_0000, a);
    err_clear = 1'b0;
    chk("set_beats_clear", 128'(err), 128'(2'b01));
    err_clear = 1'b1; @(posedge clk); #1 err_clear = 1'b0;
    chk("err_clear2", 128'(err), 128'(0));

    // Reset after ARG1: nothing written, next word is a header.
    send(32'h1100_0000, a);
    send(32'h0000_0010, a);
    send(32'h0000_0020, a);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("postrst_busy", 128'(busy), 128'(0));
    send(32'h3300_0000, a);
    push({4'b0000, 4'b1000, 1'b0}, '0, a);
    idle(3);

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_loader.md
STEP_LOADER -- requirements
Module: step_loader

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of attached step/dir channel queues, range 1..16.
REQ-002 SHALL have parameter MOVE_TYPE_BITS, default 3: move-type field width.
REQ-003 SHALL have parameter STEP_INTERVAL_BITS, default 32: interval field width, at most 32.
REQ-004 SHALL have parameter STEP_COUNT_BITS, default 32: count field width, at most 32.
REQ-005 SHALL have parameter STEP_ADD_BITS, default 32: add field width, at most 32.
REQ-006 SHALL define local width DW = MOVE_TYPE_BITS + STEP_INTERVAL_BITS + STEP_COUNT_BITS + STEP_ADD_BITS + 1.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 in_data  in  32  command word stream.
REQ-010 in_valid  in  1  in_data valid.
REQ-011 in_ready  out  1  block accepts in_data; a word transfers when in_valid and in_ready are both high on a clk edge.
REQ-012 q_wr_data  out  DW  queue entry shared by all channels, packed {dir, interval, count, add, move_type}, move_type in the LSBs.
REQ-013 q_wr_en  out  NUM_CHANNELS  one-hot per-channel queue write strobe.
REQ-014 q_full  in  NUM_CHANNELS  per-channel queue full.
REQ-015 do_reset_clock  out  1  broadcast clock-reload strobe.
REQ-016 reset_clock  out  32  reload value, valid while do_reset_clock is high.
REQ-017 ch_reset  out  NUM_CHANNELS  per-channel queue/count reset strobe.
REQ-018 busy  out  1  high in every state except HDR.
REQ-019 err  out  2  sticky flags: bit0 is bad channel, bit1 is bad opcode.
REQ-020 err_clear  in  1  clears err.

Function
REQ-021 SHALL decode each header word as: opcode in bits 31:28, channel in 27:24, dir in bit 23, move_type in the low MOVE_TYPE_BITS bits; all other header bits are ignored.
REQ-022 SHALL support three opcodes: 1 MOVE (3 argument words: interval, count, add), 2 SET_CLOCK (1 argument word), 3 CH_RESET (no arguments).
REQ-023 SHALL implement the FSM states HDR, ARG0, ARG1, ARG2, WRITE; the state after reset is HDR.
REQ-024 in_ready SHALL be high in HDR, ARG0, ARG1 and ARG2, and low in WRITE.
REQ-025 For MOVE, the FSM SHALL advance HDR->ARG0->ARG1->ARG2 on each accepted word, then move to WRITE.
REQ-026 Interval, count and add SHALL each be taken from the low bits of their argument word; upper bits are discarded.
REQ-027 In WRITE with q_full[ch] low, the block SHALL pulse q_wr_en[ch] for exactly one cycle and return to HDR.
REQ-028 In WRITE with q_full[ch] high, the block SHALL hold in WRITE with no strobe until q_full[ch] goes low.
REQ-029 Minimum latency SHALL be one cycle: q_wr_en is high in the cycle after the add word is accepted.
REQ-030 q_wr_data SHALL be registered and stable from entry into WRITE through the q_wr_en cycle.
REQ-031 SET_CLOCK SHALL pulse do_reset_clock for one cycle, in the cycle after its argument is accepted, with reset_clock equal to that argument; the channel field is ignored.
REQ-032 CH_RESET SHALL pulse ch_reset[ch] for one cycle, in the cycle after the header is accepted; the FSM stays in HDR.
REQ-033 For a channel value >= NUM_CHANNELS, MOVE SHALL consume all 3 arguments, write nothing and set err[0]; CH_RESET SHALL pulse nothing and set err[0].
REQ-034 For an unknown opcode, the block SHALL consume the header only, set err[1] and stay in HDR.
REQ-035 If an error set and err_clear occur in the same cycle, the set SHALL win.
REQ-036 At most one bit of q_wr_en and at most one bit of ch_reset SHALL be high in any cycle.
REQ-037 q_wr_en, ch_reset and do_reset_clock SHALL never be high in the same cycle.

Reset
REQ-038 While reset is high, the block SHALL force the FSM to HDR and drive in_ready=0, q_wr_en=0, ch_reset=0, do_reset_clock=0, reset_clock=0, q_wr_data=0, err=0, busy=0.
REQ-039 A reset in the middle of a command SHALL discard any partial command; after reset deasserts, the next accepted word SHALL be decoded as a header.

Verification
REQ-040 MOVE to channel 2 (dir=1, type=0; interval 0x100, count 5, add 0xFFFFFFFE) with q_full=0: q_wr_en=4'b0100 for one cycle, one cycle after the add word; q_wr_data = {1, 0x100, 5, 0xFFFFFFFE, 3'b000}.
REQ-041 Same MOVE with q_full[2]=1 held for 10 cycles: in_ready=0 and no strobe during those cycles; q_wr_en[2] pulses the cycle after q_full[2] drops.
REQ-042 SET_CLOCK with argument 0x12345678: do_reset_clock=1 for one cycle with reset_clock=0x12345678.
REQ-043 MOVE to channel 7 with NUM_CHANNELS=4: three arguments consumed, no q_wr_en, err=2'b01; a following err_clear returns err to 0.
REQ-044 Opcode 0xF header: err[1]=1; a following CH_RESET for channel 1 gives ch_reset=4'b0010.
REQ-045 reset asserted after ARG1: no q_wr_en; the next word after reset is decoded as a header.
